// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the IF/MEM sram-like port arbiter.
// Source tags match mycpu.h: SRC_INST=0, SRC_DATA=1.
package sram_like_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_e;

   typedef struct packed {
      logic              req;
      logic              wr;
      logic [1:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_req_src_fifo.sv
// In-order record of which requester owns each accepted, not-yet-returned request.
// Pointers wrap naturally because DEPTH is a power of two.
module req_src_fifo
   import sram_like_arbiter_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  src_e             push_src,
   input  logic             pop,
   output src_e             head_src,
   output logic [CNT_W-1:0] count
);

   src_e             src_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are unreachable once count is cleared.
   always_ff @(posedge clk) begin
      if (push) src_mem[wr_ptr] <= push_src;
   end

   assign head_src = src_mem[rd_ptr];

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between IF (inst) and MEM (data) requesters:
// grant lock until addr_ok, starvation guard for inst, in-order response routing.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int OUTSTANDING  = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              err_stray
);

   localparam int CNT_W = $clog2(OUTSTANDING) + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   sram_req_t        inst_side;
   sram_req_t        data_side;
   sram_req_t        win_side;
   src_e             winner;
   src_e             lock_src;
   src_e             head_src;
   logic             locked;
   logic             full;
   logic             accept;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic [STV_W-1:0] starve_cnt;

   assign inst_side = '{inst_req, inst_wr, inst_size, inst_addr, inst_wdata};
   assign data_side = '{data_req, data_wr, data_size, data_addr, data_wdata};

   // Data wins contention unless inst has been passed over STARVE_LIMIT times in a row.
   always_comb begin
      winner = SRC_DATA;
      if (locked)
         winner = lock_src;
      else if (inst_req && !data_req)
         winner = SRC_INST;
      else if (inst_req && data_req && (starve_cnt == STV_W'(STARVE_LIMIT)))
         winner = SRC_INST;
   end

   assign win_side = (winner == SRC_INST) ? inst_side : data_side;

   // Registered count only: a same-cycle return does not open a slot.
   assign full = (count == CNT_W'(OUTSTANDING));

   assign mem_req   = win_side.req & ~full;
   assign mem_wr    = win_side.wr;
   assign mem_size  = win_side.size;
   assign mem_addr  = win_side.addr;
   assign mem_wdata = win_side.wdata;

   assign accept       = mem_req & mem_addr_ok;
   assign inst_addr_ok = accept & (winner == SRC_INST);
   assign data_addr_ok = accept & (winner == SRC_DATA);

   assign pop          = mem_data_ok & (count != '0);
   assign inst_data_ok = pop & (head_src == SRC_INST);
   assign data_data_ok = pop & (head_src == SRC_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   req_src_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_src_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (accept),
      .push_src (winner),
      .pop      (pop),
      .head_src (head_src),
      .count    (count)
   );

   // A presented but unaccepted request pins the grant to its side.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         locked   <= 1'b0;
         lock_src <= SRC_INST;
      end else if (mem_req && !mem_addr_ok) begin
         locked   <= 1'b1;
         lock_src <= winner;
      end else if (accept) begin
         locked   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (inst_addr_ok) begin
         starve_cnt <= '0;
      end else if (data_addr_ok) begin
         if (!inst_req)
            starve_cnt <= '0;
         else if (starve_cnt != STV_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + STV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         err_stray <= 1'b0;
      else if (mem_data_ok && (count == '0))
         err_stray <= 1'b1;
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: vector table plus directed sequences,
// with a source scoreboard filled on expected accepts and drained on returns.
module tb_sram_like_arbiter;
   import sram_like_arbiter_pkg::*;

   localparam logic [31:0] IA = 32'h1000_0100;
   localparam logic [31:0] DA = 32'h2000_0200;
   localparam logic [31:0] IW = 32'hCAFE_0001;
   localparam logic [31:0] DW = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
   logic [1:0]  inst_size = 0, data_size = 0;
   logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok = 0, mem_data_ok = 0;
   logic [31:0] mem_rdata = 0;
   logic        err_stray;

   int n_tests = 0;
   int n_fail  = 0;
   src_e sb[$];

   typedef struct {
      logic        ireq, dreq, aok, dok;
      logic [31:0] rd;
      logic        x_mreq, x_iak, x_dak;
      src_e        x_win;
   } vec_t;
   vec_t tbl [9];

   sram_like_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .err_stray(err_stray)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_mem_req"}, {31'd0, mem_req}, 0);
      chk({p, "_mem_wr"}, {31'd0, mem_wr}, 0);
      chk({p, "_mem_size"}, {30'd0, mem_size}, 0);
      chk({p, "_mem_addr"}, mem_addr, 0);
      chk({p, "_mem_wdata"}, mem_wdata, 0);
      chk({p, "_inst_addr_ok"}, {31'd0, inst_addr_ok}, 0);
      chk({p, "_data_addr_ok"}, {31'd0, data_addr_ok}, 0);
      chk({p, "_inst_data_ok"}, {31'd0, inst_data_ok}, 0);
      chk({p, "_data_data_ok"}, {31'd0, data_data_ok}, 0);
      chk({p, "_inst_rdata"}, inst_rdata, 0);
      chk({p, "_data_rdata"}, data_rdata, 0);
      chk({p, "_err_stray"}, {31'd0, err_stray}, 0);
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 0;
      #1 chk_zero("rst");
      @(negedge clk);
      @(negedge clk);
      resetn = 1;
      #1 chk_zero("idle");
      @(negedge clk);
      sb.delete();
   endtask

   // One clock: drive at negedge, check 1ns later, return on the next negedge.
   task automatic tick(input logic ireq, input logic dreq, input logic aok, input logic dok,
                       input logic [31:0] rd, input logic x_mreq, input logic x_iak,
                       input logic x_dak, input src_e x_win);
      src_e e;
      inst_req = ireq; inst_wr = 0; inst_size = SZ_W; inst_addr = IA; inst_wdata = IW;
      data_req = dreq; data_wr = 1; data_size = SZ_H; data_addr = DA; data_wdata = DW;
      mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
      #1;
      chk("mem_req", {31'd0, mem_req}, {31'd0, x_mreq});
      chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, x_iak});
      chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, x_dak});
      if (x_mreq) begin
         chk("mem_addr", mem_addr, (x_win == SRC_INST) ? IA : DA);
         chk("mem_wr", {31'd0, mem_wr}, {31'd0, (x_win == SRC_DATA)});
         chk("mem_size", {30'd0, mem_size}, {30'd0, (x_win == SRC_INST) ? SZ_W : SZ_H});
         chk("mem_wdata", mem_wdata, (x_win == SRC_INST) ? IW : DW);
      end
      if (dok && sb.size() != 0) begin
         e = sb.pop_front();
         chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, (e == SRC_INST)});
         chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, (e == SRC_DATA)});
         if (e == SRC_INST) chk("inst_rdata", inst_rdata, rd);
         else               chk("data_rdata", data_rdata, rd);
      end else begin
         chk("inst_data_ok_quiet", {31'd0, inst_data_ok}, 0);
         chk("data_data_ok_quiet", {31'd0, data_data_ok}, 0);
      end
      if (x_iak) sb.push_back(SRC_INST);
      if (x_dak) sb.push_back(SRC_DATA);
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, SRC_DATA};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, SRC_INST};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, SRC_DATA};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, SRC_DATA};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 1'b0, 1'b1, SRC_DATA};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1, 1'b0, SRC_INST};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, SRC_DATA};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, SRC_DATA};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, SRC_DATA};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 9; i++)
         tick(tbl[i].ireq, tbl[i].dreq, tbl[i].aok, tbl[i].dok, tbl[i].rd,
              tbl[i].x_mreq, tbl[i].x_iak, tbl[i].x_dak, tbl[i].x_win);

      // single inst word read, return two cycles after accept
      do_reset();
      tick(1, 0, 1, 0, 32'h0, 1, 1, 0, SRC_INST);
      tick(0, 0, 0, 0, 32'h0, 0, 0, 0, SRC_DATA);
      tick(0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, SRC_DATA);

      // simultaneous requests: data first, inst next, returns in order
      tick(1, 1, 1, 0, 32'h0, 1, 0, 1, SRC_DATA);
      tick(1, 0, 1, 0, 32'h0, 1, 1, 0, SRC_INST);
      tick(0, 0, 0, 1, 32'hAAAA_0001, 0, 0, 0, SRC_DATA);
      tick(0, 0, 0, 1, 32'hBBBB_0002, 0, 0, 0, SRC_DATA);

      // grant stays locked on inst while data arrives mid-handshake
      tick(1, 0, 0, 0, 32'h0, 1, 0, 0, SRC_INST);
      tick(1, 1, 0, 0, 32'h0, 1, 0, 0, SRC_INST);
      tick(1, 1, 0, 0, 32'h0, 1, 0, 0, SRC_INST);
      tick(1, 1, 1, 0, 32'h0, 1, 1, 0, SRC_INST);
      tick(0, 1, 1, 0, 32'h0, 1, 0, 1, SRC_DATA);
      tick(0, 0, 0, 1, 32'h0000_0C01, 0, 0, 0, SRC_DATA);
      tick(0, 0, 0, 1, 32'h0000_0C02, 0, 0, 0, SRC_DATA);

      // fill to OUTSTANDING, stall, single return gives one bubble then a grant
      do_reset();
      for (int k = 0; k < 4; k++) tick(1, 1, 1, 0, 32'h0, 1, 0, 1, SRC_DATA);
      tick(1, 1, 1, 0, 32'h0, 0, 0, 0, SRC_DATA);
      tick(1, 1, 1, 0, 32'h0, 0, 0, 0, SRC_DATA);
      tick(1, 1, 1, 1, 32'h0000_0F01, 0, 0, 0, SRC_DATA);
      tick(1, 1, 1, 0, 32'h0, 1, 0, 1, SRC_DATA);
      tick(1, 1, 1, 0, 32'h0, 0, 0, 0, SRC_DATA);
      for (int k = 0; k < 4; k++) tick(0, 0, 0, 1, 32'h0000_0F10 + k, 0, 0, 0, SRC_DATA);

      // starvation guard: every ninth contended accept goes to inst
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         logic ii;
         ii = ((k % 9) == 0);
         tick(1, 1, 1, (k > 1), 32'h5000_0000 + k, 1, ii, !ii, ii ? SRC_INST : SRC_DATA);
      end
      tick(0, 0, 0, 1, 32'h5000_0099, 0, 0, 0, SRC_DATA);

      // stray return sets sticky error, reset clears it
      do_reset();
      tick(0, 0, 0, 1, 32'h0000_0777, 0, 0, 0, SRC_DATA);
      chk("err_stray_set", {31'd0, err_stray}, 1);
      tick(0, 0, 0, 0, 32'h0, 0, 0, 0, SRC_DATA);
      chk("err_stray_sticky", {31'd0, err_stray}, 1);
      do_reset();

      // reset with three requests outstanding discards them
      for (int k = 0; k < 3; k++) tick(1, 0, 1, 0, 32'h0, 1, 1, 0, SRC_INST);
      idle_inputs();
      mem_data_ok = 1;
      resetn = 0;
      #1;
      chk("midrst_inst_data_ok", {31'd0, inst_data_ok}, 0);
      chk("midrst_data_data_ok", {31'd0, data_data_ok}, 0);
      chk("midrst_mem_req", {31'd0, mem_req}, 0);
      chk("midrst_err_stray", {31'd0, err_stray}, 0);
      @(negedge clk);
      mem_data_ok = 0;
      @(negedge clk);
      resetn = 1;
      sb.delete();
      @(negedge clk);
      tick(0, 0, 0, 1, 32'h0000_0888, 0, 0, 0, SRC_DATA);
      chk("late_return_err_stray", {31'd0, err_stray}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
